// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Holds the FSM state encoding, the default bytes-per-word and the byte-counter width.
package regdump_pkg;

  // Width of a counter that indexes n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NB_DATA_DFLT = 32;
  localparam int NB_BYTE_DFLT = 8;
  localparam int BPW          = NB_DATA_DFLT / NB_BYTE_DFLT;
  localparam int NB_BCNT      = cnt_width(BPW);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Debug-unit / register-file / byte-stream signal bundle for the dump sequencer.
// Latency: n/a (wires only).
// Backpressure: stream uses o_tx_valid / i_tx_ready; slave = sequencer view, master = environment view.
// Signals: i_start, i_abort (requests), o_address_read_debug / i_data_read_debug (regfile debug port),
//          o_tx_data / o_tx_valid / i_tx_ready (byte stream), o_halt, o_busy, o_done (status).
interface regfile_dump_ctrl_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
);
  logic               i_start;
  logic               i_abort;
  logic [NB_REG-1:0]  o_address_read_debug;
  logic [NB_DATA-1:0] i_data_read_debug;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_halt;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_start, i_abort, i_data_read_debug, i_tx_ready,
    output o_address_read_debug, o_tx_data, o_tx_valid, o_halt, o_busy, o_done
  );

  modport master (
    output i_start, i_abort, i_data_read_debug, i_tx_ready,
    input  o_address_read_debug, o_tx_data, o_tx_valid, o_halt, o_busy, o_done
  );
endinterface

// File: rtl/regdump_word_serializer.sv
// Word-to-byte serializer: captures one word on load and presents it LSB byte first.
// Latency: first byte valid the cycle after load; one byte per cycle while ready is high.
// Backpressure: byte and valid held unchanged while active and !tx_ready; no timeout.
// Ports: clk, rst_n, load, word_in, active (present bytes), tx_ready -> tx_data, tx_valid,
//        byte_fire (byte accepted this cycle), last_byte (current byte is the word's last).
module regdump_word_serializer
  import regdump_pkg::*;
#(
  parameter int NB_BYTE = NB_BYTE_DFLT,
  parameter int N_BYTES = BPW,
  parameter int CNT_W   = cnt_width(N_BYTES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [N_BYTES*NB_BYTE-1:0] word_in,
  input  logic                       active,
  input  logic                       tx_ready,
  output logic [NB_BYTE-1:0]         tx_data,
  output logic                       tx_valid,
  output logic                       byte_fire,
  output logic                       last_byte
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  logic [N_BYTES-1:0][NB_BYTE-1:0] word_q;
  logic [CNT_W-1:0]                byte_cnt_q;

  assign tx_valid  = active;
  assign byte_fire = active & tx_ready;
  assign last_byte = (byte_cnt_q == LAST_IDX);
  // Idle data reads as zero so the stream lines are quiet outside a transfer.
  assign tx_data   = active ? word_q[byte_cnt_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else if (load) begin
      word_q     <= word_in;
      byte_cnt_q <= '0;
    end else if (byte_fire && !last_byte) begin
      byte_cnt_q <= byte_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: halts the pipeline and streams r0..r(NUM_REGS-1) LSB byte first.
// Latency: 1 READ cycle + BPW byte cycles per word; o_done one cycle after the final byte is accepted.
// Backpressure: stream stalls indefinitely on !i_tx_ready; i_abort returns to IDLE and drops valid.
// Ports: i_clk, i_reset (async active-low), dbg (regfile_dump_ctrl_if.slave: start/abort, regfile
//        debug address/data, byte stream valid/ready, halt/busy/done status).
// Build option: REGDUMP_CHECKSUM_EN appends one XOR-of-all-data-bytes byte after the last register.
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DFLT,
  parameter int NB_REG   = 5,
  parameter int NB_BYTE  = NB_BYTE_DFLT,
  parameter int NUM_REGS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  regfile_dump_ctrl_if.slave dbg
);

  localparam int               WORD_BYTES = NB_DATA / NB_BYTE;
  localparam logic [NB_REG-1:0] LAST_REG  = NB_REG'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [NB_REG-1:0]   reg_idx_q;
  logic                start_go, load, idx_inc, last_reg, word_done;
  logic                ser_valid, ser_fire, ser_last;
  logic [NB_BYTE-1:0]  ser_data;

  assign start_go  = (state_q == ST_IDLE) && dbg.i_start;
  assign last_reg  = (reg_idx_q == LAST_REG);
  assign word_done = ser_fire & ser_last;

  regdump_word_serializer #(
    .NB_BYTE (NB_BYTE),
    .N_BYTES (WORD_BYTES)
  ) u_ser (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .load      (load),
    .word_in   (dbg.i_data_read_debug),
    .active    (state_q == ST_SEND),
    .tx_ready  (dbg.i_tx_ready),
    .tx_data   (ser_data),
    .tx_valid  (ser_valid),
    .byte_fire (ser_fire),
    .last_byte (ser_last)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    idx_inc = 1'b0;
    // Abort outranks every other event once a dump is under way.
    if (state_q != ST_IDLE && dbg.i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (dbg.i_start) state_d = ST_READ;
        // Address has been stable for a full cycle; capture the read data.
        ST_READ: begin
          load    = 1'b1;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (word_done) begin
            if (last_reg) begin
`ifdef REGDUMP_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              idx_inc = 1'b1;
              state_d = ST_READ;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        ST_CSUM: if (dbg.i_tx_ready) state_d = ST_DONE;
`endif
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register index doubles as the registered debug read address; it never wraps.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      reg_idx_q <= '0;
    end else if (start_go) begin
      reg_idx_q <= '0;
    end else if (idx_inc) begin
      reg_idx_q <= reg_idx_q + NB_REG'(1);
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      csum_q <= '0;
    end else if (start_go) begin
      csum_q <= '0;
    end else if (ser_fire) begin
      csum_q <= csum_q ^ ser_data;
    end
  end

  assign dbg.o_tx_valid = ser_valid | (state_q == ST_CSUM);
  assign dbg.o_tx_data  = (state_q == ST_CSUM) ? csum_q : ser_data;
`else
  assign dbg.o_tx_valid = ser_valid;
  assign dbg.o_tx_data  = ser_data;
`endif

  assign dbg.o_address_read_debug = reg_idx_q;
  assign dbg.o_busy               = (state_q != ST_IDLE);
  assign dbg.o_halt               = (state_q != ST_IDLE);
  assign dbg.o_done               = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: table-driven dumps, randomized dumps and corner sequences.
// Latency: n/a.
// Backpressure: the bench drives i_tx_ready with configurable random duty.
module tb_regfile_dump_ctrl;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif
  localparam int NREG    = 32;
  localparam int EXP_CYC = NREG * 5 + CSUM_EXTRA;
  localparam int MAX_CYC = 5000;

  logic clk;
  logic rst_n;
  logic [31:0] rf [NREG];
  logic [7:0]  exp_q [$];
  logic [7:0]  cap_q [$];
  int          n_checks;
  int          n_errors;
  int          done_cnt;
  int          halt_low;

  regfile_dump_ctrl_if #(.NB_DATA(32), .NB_REG(5), .NB_BYTE(8)) dbg ();

  regfile_dump_ctrl #(.NB_DATA(32), .NB_REG(5), .NB_BYTE(8), .NUM_REGS(NREG)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .dbg     (dbg)
  );

  assign dbg.i_data_read_debug = rf[dbg.o_address_read_debug];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sink model: records every accepted byte and counts done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg.o_tx_valid && dbg.i_tx_ready && !dbg.i_abort) cap_q.push_back(dbg.o_tx_data);
      if (dbg.o_done) done_cnt++;
    end
  end

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    int          rdy_pct;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] out_vec();
    return {dbg.o_tx_valid, dbg.o_tx_data, dbg.o_halt, dbg.o_busy, dbg.o_done,
            dbg.o_address_read_debug};
  endfunction

  // Reference stream: every register LSB byte first, optional XOR trailer.
  function automatic void build_expected();
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    exp_q.delete();
    for (int i = 0; i < NREG; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = rf[i][8*k +: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
    if (CSUM_EXTRA != 0) exp_q.push_back(x);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered at posedge+1 in IDLE; leaves at posedge+1 of the first READ cycle.
  task automatic start_dump();
    cap_q.delete();
    done_cnt = 0;
    halt_low = 0;
    dbg.i_start = 1'b1;
    step(1);
    dbg.i_start = 1'b0;
  endtask

  task automatic drive_until_done(input int rdy_pct, input bit start_in_done,
                                  output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 0; c < MAX_CYC; c++) begin
      dbg.i_tx_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (!dbg.o_halt) halt_low++;
      if (dbg.o_done) begin
        ok = 1'b1;
        break;
      end
      step(1);
      cyc++;
    end
    if (start_in_done) dbg.i_start = 1'b1;
    step(1);
    dbg.i_start    = 1'b0;
    dbg.i_tx_ready = 1'b1;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, " len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  task automatic run_dump(input string tag, input int rdy_pct, input int exp_cyc);
    int cyc;
    bit ok;
    build_expected();
    start_dump();
    drive_until_done(rdy_pct, 1'b0, cyc, ok);
    check({tag, " done seen"}, ok, 1);
    if (exp_cyc >= 0) check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " halt low"}, halt_low, 0);
    compare_stream(tag);
  endtask

  initial begin
    int  cyc;
    bit  ok;
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    halt_low = 0;
    rst_n          = 1'b0;
    dbg.i_start    = 1'b0;
    dbg.i_abort    = 1'b0;
    dbg.i_tx_ready = 1'b1;
    for (int i = 0; i < NREG; i++) rf[i] = 32'h0;

    vecs[0] = '{32'h0000_0000, 32'h0101_0101, 100, EXP_CYC};
    vecs[1] = '{32'hDEAD_BEEF, 32'h0123_4567, 100, EXP_CYC};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 100, EXP_CYC};
    vecs[3] = '{$urandom(), $urandom(), 100, EXP_CYC};
    vecs[4] = '{$urandom(), $urandom(), 50, -1};
    vecs[5] = '{$urandom(), $urandom(), 25, -1};

    #3;
    check("reset outputs", out_vec(), 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("idle outputs", out_vec(), 17'h0);

    // Table-driven dumps.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NREG; i++) rf[i] = vecs[v].base + vecs[v].step * i;
      run_dump($sformatf("vec%0d", v), vecs[v].rdy_pct, vecs[v].exp_cyc);
    end

    // Randomized data and ready duty.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++) rf[i] = $urandom();
      run_dump($sformatf("rand%0d", r), $urandom_range(20, 100), -1);
    end

    // Async reset in SEND of r5, then a clean dump from r0.
    for (int i = 0; i < NREG; i++) rf[i] = 32'h0101_0101 * i;
    start_dump();
    step(27);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", out_vec(), 17'h0);
    step(1);
    check("reset held outputs", out_vec(), 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    run_dump("after reset", 100, EXP_CYC);

    // Backpressure on byte 2 of r1.
    rf[1] = 32'hDDCC_BBAA;
    build_expected();
    start_dump();
    step(8);
    dbg.i_tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp hold data %0d", k), dbg.o_tx_data, 8'hCC);
      check($sformatf("bp hold valid %0d", k), dbg.o_tx_valid, 1);
      step(1);
    end
    dbg.i_tx_ready = 1'b1;
    @(negedge clk);
    check("bp release data", dbg.o_tx_data, 8'hCC);
    step(1);
    @(negedge clk);
    check("bp next data", dbg.o_tx_data, 8'hDD);
    check("bp next valid", dbg.o_tx_valid, 1);
    drive_until_done(100, 1'b0, cyc, ok);
    check("bp done seen", ok, 1);
    compare_stream("bp");

    // Start pulsed in SEND and in DONE: ignored.
    start_dump();
    step(2);
    dbg.i_start = 1'b1;
    step(1);
    dbg.i_start = 1'b0;
    drive_until_done(100, 1'b1, cyc, ok);
    check("busy start done seen", ok, 1);
    check("busy start cycles", cyc, EXP_CYC - 3);
    step(40);
    @(negedge clk);
    check("busy start idle", dbg.o_busy, 0);
    check("busy start done count", done_cnt, 1);
    compare_stream("busy start");
    step(1);

    // Abort in READ of r7, then restart from r0.
    start_dump();
    step(35);
    @(negedge clk);
    check("abort addr r7", dbg.o_address_read_debug, 7);
    check("abort read valid", dbg.o_tx_valid, 0);
    dbg.i_abort = 1'b1;
    step(1);
    dbg.i_abort = 1'b0;
    @(negedge clk);
    check("abort vld/halt/busy", {dbg.o_tx_valid, dbg.o_halt, dbg.o_busy}, 3'b000);
    step(20);
    check("abort no done", done_cnt, 0);
    check("abort stays idle", dbg.o_busy, 0);
    start_dump();
    @(negedge clk);
    check("restart addr", dbg.o_address_read_debug, 0);
    check("restart busy", dbg.o_busy, 1);
    drive_until_done(100, 1'b0, cyc, ok);
    check("restart done seen", ok, 1);
    check("restart done count", done_cnt, 1);
    compare_stream("restart");

    // Checksum trailer (or its absence).
    for (int i = 0; i < NREG; i++) rf[i] = 32'h0;
    rf[3] = 32'h0000_00FF;
    run_dump("csum", 100, EXP_CYC);
    check("csum stream len", cap_q.size(), NREG * 4 + CSUM_EXTRA);
    if (cap_q.size() > 0)
      check("csum last byte", cap_q[cap_q.size()-1], (CSUM_EXTRA != 0) ? 8'hFF : 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
